// File: rtl/timer_host_master_pkg.sv
`default_nettype none
// ============================================================================
// timer_host_master_pkg : interval-timer register map, control bits, FSM states
// Revision 1.0
// ============================================================================
package timer_host_master_pkg;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;
   localparam logic [2:0] ADDR_SNAPL   = 3'd4;
   localparam logic [2:0] ADDR_SNAPH   = 3'd5;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   localparam logic [15:0] CTRL_STOP_WORD = 16'h0001 << CTRL_STOP;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_STOP0  = 4'd1,
      S_PERL   = 4'd2,
      S_PERH   = 4'd3,
      S_CLRST  = 4'd4,
      S_START  = 4'd5,
      S_WAIT   = 4'd6,
      S_RDST   = 4'd7,
      S_RDCHK  = 4'd8,
      S_ACK    = 4'd9,
      S_SETTLE = 4'd10,
      S_STOP1  = 4'd11,
      S_DONE   = 4'd12
   } state_t;

   function automatic logic [15:0] start_word(input logic cont, input logic ito);
      logic [15:0] w;
      w             = 16'h0000;
      w[CTRL_START] = 1'b1;
      w[CTRL_CONT]  = cont;
      w[CTRL_ITO]   = ito;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/avmm_wr_rd_port.sv
`default_nettype none
// ============================================================================
// avmm_wr_rd_port : registers one single-cycle Avalon-MM access, flags read data
// Revision 1.0
// ============================================================================
module avmm_wr_rd_port (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid_i,
   input  logic        req_write_i,
   input  logic [2:0]  req_addr_i,
   input  logic [15:0] req_wdata_i,
   output logic [2:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [15:0] m_writedata,
   input  logic [15:0] m_readdata,
   output logic        rd_hit_o
);

   logic [2:0]  addr_q;
   logic        cs_q;
   logic        wn_q;
   logic [15:0] wdata_q;
   logic        rd_pend_q;
   logic        unused_rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= 3'd0;
         cs_q      <= 1'b0;
         wn_q      <= 1'b1;
         wdata_q   <= 16'h0000;
         rd_pend_q <= 1'b0;
      end else begin
         // Read data is valid the cycle after the read is on the bus.
         rd_pend_q <= cs_q & wn_q;
         if (req_valid_i) begin
            addr_q  <= req_addr_i;
            cs_q    <= 1'b1;
            wn_q    <= ~req_write_i;
            wdata_q <= req_write_i ? req_wdata_i : 16'h0000;
         end else begin
            addr_q  <= 3'd0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wdata_q <= 16'h0000;
         end
      end
   end

   assign m_address    = addr_q;
   assign m_chipselect = cs_q;
   assign m_write_n    = wn_q;
   assign m_writedata  = wdata_q;
   assign rd_hit_o     = rd_pend_q & m_readdata[0];
   assign unused_rdata = ^m_readdata[15:1];

endmodule
`default_nettype wire

// File: rtl/timer_host_master.sv
`default_nettype none
// ============================================================================
// timer_host_master : runs timer jobs (program, start, service timeouts, stop)
// Revision 1.0
// ============================================================================
module timer_host_master
   import timer_host_master_pkg::*;
#(
   parameter int POLL_MODE = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_period,
   input  logic [15:0] cmd_count,
   input  logic        cmd_continuous,
   input  logic        abort,
   output logic [2:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [15:0] m_writedata,
   input  logic [15:0] m_readdata,
   input  logic        m_irq,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic [15:0] ticks
);

   localparam logic ITO_EN = (POLL_MODE == 0);

   state_t      state_q, state_d;
   logic [31:0] period_q, period_d;
   logic [15:0] count_q, count_d;
   logic        cont_q, cont_d;
   logic [15:0] ticks_q, ticks_d;
   logic        aborted_q, aborted_d;
   logic        busy_q;
   logic        done_q;
   logic        cmd_ready_q;

   logic        w_req_valid;
   logic        w_req_write;
   logic [2:0]  w_req_addr;
   logic [15:0] w_req_wdata;
   logic        w_rd_hit;
   logic        w_abortable;

   assign w_abortable = (state_q != S_IDLE) && (state_q != S_STOP1) && (state_q != S_DONE);

   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      count_d   = count_q;
      cont_d    = cont_q;
      ticks_d   = ticks_q;
      aborted_d = aborted_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               period_d  = cmd_period;
               count_d   = cmd_count;
               cont_d    = cmd_continuous;
               ticks_d   = 16'h0000;
               aborted_d = 1'b0;
               state_d   = S_STOP0;
            end
         end
         S_STOP0: state_d = S_PERL;
         S_PERL:  state_d = S_PERH;
         S_PERH:  state_d = S_CLRST;
         S_CLRST: state_d = S_START;
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (POLL_MODE != 0)
               state_d = S_RDST;
            else if (m_irq)
               state_d = S_ACK;
         end
         S_RDST:  state_d = S_RDCHK;
         S_RDCHK: state_d = w_rd_hit ? S_ACK : S_WAIT;
         S_ACK: begin
            if (ticks_q != 16'hFFFF)
               ticks_d = ticks_q + 16'd1;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (((count_q != 16'd0) && (ticks_q == count_q)) || !cont_q)
               state_d = S_STOP1;
            else
               state_d = S_WAIT;
         end
         S_STOP1: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort overrides any pending timeout hit, so WAIT/RDCHK never reach ACK.
      if (abort && w_abortable) begin
         aborted_d = 1'b1;
         state_d   = S_STOP1;
      end
   end

   // The bus access belonging to a state is registered on entry to that state.
   always_comb begin
      w_req_valid = 1'b1;
      w_req_write = 1'b1;
      w_req_addr  = ADDR_STATUS;
      w_req_wdata = 16'h0000;
      case (state_d)
         S_STOP0, S_STOP1: begin
            w_req_addr  = ADDR_CONTROL;
            w_req_wdata = CTRL_STOP_WORD;
         end
         S_PERL: begin
            w_req_addr  = ADDR_PERIODL;
            w_req_wdata = period_q[15:0];
         end
         S_PERH: begin
            w_req_addr  = ADDR_PERIODH;
            w_req_wdata = period_q[31:16];
         end
         S_CLRST, S_ACK: ;
         S_START: begin
            w_req_addr  = ADDR_CONTROL;
            w_req_wdata = start_word(cont_q, ITO_EN);
         end
         S_RDST:  w_req_write = 1'b0;
         default: w_req_valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         period_q    <= 32'h0000_0000;
         count_q     <= 16'h0000;
         cont_q      <= 1'b0;
         ticks_q     <= 16'h0000;
         aborted_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         count_q     <= count_d;
         cont_q      <= cont_d;
         ticks_q     <= ticks_d;
         aborted_q   <= aborted_d;
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_DONE);
         cmd_ready_q <= (state_d == S_IDLE);
      end
   end

   avmm_wr_rd_port u_port (
      .clk          (clk),
      .reset        (reset),
      .req_valid_i  (w_req_valid),
      .req_write_i  (w_req_write),
      .req_addr_i   (w_req_addr),
      .req_wdata_i  (w_req_wdata),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata),
      .rd_hit_o     (w_rd_hit)
   );

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign aborted   = aborted_q;
   assign ticks     = ticks_q;

endmodule
`default_nettype wire

// File: doc/timer_host_master.md
TIMER_HOST_MASTER -- requirements
Module: timer_host_master

Interface
REQ-001 SHALL have parameter POLL_MODE, default 0; 0 = wait on timer irq, 1 = poll status register (address 0) by Avalon read.
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_period in 32, cmd_count in 16, cmd_continuous in 1: a job is accepted when valid && ready.
REQ-005 SHALL have port abort  in  1  single-cycle request to terminate the running job.
REQ-006 SHALL have ports m_address out 3, m_chipselect out 1, m_write_n out 1, m_writedata out 16: Avalon-MM initiator to the 16-bit interval-timer slave.
REQ-007 SHALL have ports m_readdata in 16 (valid one cycle after a read issue) and m_irq in 1 (timer level interrupt).
REQ-008 SHALL have ports busy out 1, done out 1 (one-cycle pulse), aborted out 1 (valid with done), ticks out 16 (timeouts serviced in current/last job).

Function
REQ-009 Every bus access SHALL last exactly one cycle: chipselect=1, address, write_n, writedata held for that cycle only. No waitrequest exists.
REQ-010 When idle, the block SHALL drive chipselect=0, write_n=1, address=0, writedata=0.
REQ-011 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state except IDLE.
REQ-012 FSM states SHALL be: IDLE, STOP0, PERL, PERH, CLRST, START, WAIT, RDST, RDCHK, ACK, SETTLE, STOP1, DONE.
REQ-013 On acceptance, the block SHALL latch period, count, and continuous, clear ticks, and go to STOP0.
REQ-014 STOP0 SHALL write 0x0008 to address 1, then go to PERL.
REQ-015 PERL SHALL write period[15:0] to address 2; PERH SHALL then write period[31:16] to address 3.
REQ-016 CLRST SHALL write 0x0000 to address 0.
REQ-017 START SHALL write to address 1 the value {stop=0, start=1, cont=cmd_continuous, ito=~POLL_MODE}; e.g. 0x0007 for continuous irq mode.
REQ-018 In WAIT with POLL_MODE=0, m_irq=1 SHALL go to ACK; with POLL_MODE=1, WAIT SHALL go directly to RDST.
REQ-019 RDST SHALL issue a read of address 0. RDCHK SHALL sample m_readdata[0]: if 1, go to ACK; if 0, go to WAIT.
REQ-020 ACK SHALL write 0x0000 to address 0 and increment ticks, saturating at 0xFFFF.
REQ-021 SETTLE SHALL be one idle bus cycle so the cleared irq deasserts before it is sampled again. Then:
  - go to STOP1 if count!=0 and ticks==count;
  - go to STOP1 if not continuous;
  - else go to WAIT.
REQ-022 count==0 SHALL mean run until abort.
REQ-023 STOP1 SHALL write 0x0008 to address 1. DONE SHALL pulse done for one cycle and return to IDLE.
REQ-024 abort seen in any state from PERL to SETTLE SHALL set the aborted flag; the next state SHALL be STOP1, after the current single-cycle access completes.
REQ-025 abort in STOP0 SHALL also set aborted and go to STOP1. abort in IDLE, STOP1 or DONE SHALL be ignored.
REQ-026 aborted SHALL be cleared on acceptance of a new job.
REQ-027 If abort and an irq/status hit occur in the same WAIT/RDCHK cycle, abort SHALL win and ticks SHALL NOT increment.
REQ-028 cmd_valid during busy SHALL be ignored; the command is not queued.

Reset
REQ-029 Reset SHALL force IDLE with: bus outputs as in REQ-010, cmd_ready=1, busy=0, done=0, aborted=0, ticks=0, latched job registers=0.
REQ-030 Reset mid-job SHALL abandon the job without issuing a stop write; the timer is the peripheral's responsibility on shared reset.

Structure
REQ-031 A shared package SHALL hold:
  - timer register addresses (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5);
  - control bit positions (ITO=0, CONT=1, START=2, STOP=3);
  - the FSM state encoding.
REQ-032 One sub-module, avmm_wr_rd_port, SHALL register the single-cycle bus request and the read-data capture. The FSM SHALL live in the top module.

Verification
REQ-033 Scenario: period=0x0001_86A0, count=3, cont=1, irq mode, with a timer model.
  - Required bus writes in order: (1,0x8), (2,0x86A0), (3,0x0001), (0,0), (1,0x7).
  - Then exactly 3 ACK writes (0,0), then (1,0x8).
  - done pulses once; ticks=3, aborted=0.
REQ-034 Scenario: POLL_MODE=1, period=10, count=1, cont=0.
  - START writes 0x0004.
  - Repeated reads of address 0 follow, each with chipselect=1, write_n=1.
  - First RDCHK with readdata[0]=1 → ACK, STOP1, done; ticks=1.
REQ-035 Scenario: count=0, cont=1; abort after 5 irqs.
  - Required: ticks=5, next access is (1,0x8), done with aborted=1.
REQ-036 Scenario: abort asserted in the same cycle as m_irq in WAIT.
  - Required: no ACK write, ticks unchanged, STOP1 follows.
REQ-037 Scenario: cmd_valid held during busy, then reset asserted mid-WAIT.
  - Required: second command not accepted.
  - After reset: all outputs at REQ-029 values; cmd_ready=1 in the cycle after reset release.
